// File: rtl/bcd_countdown_timer_pkg.sv
// Shared BCD clock package: FSM state encoding, packed-BCD limits and a
// digit-validity helper. Used by the countdown timer and the 12-hour clock.
package bcd_countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  localparam logic [7:0] BCD_59 = 8'h59;  // minutes/seconds wrap value
  localparam logic [7:0] BCD_09 = 8'h09;  // units digit wrap value

  // True when both nibbles are decimal digits and the pair is <= max_v.
  // Packed BCD orders the same as its hex reading, so a plain compare works.
  function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] max_v);
    return (v[7:4] <= BCD_09[3:0]) && (v[3:0] <= BCD_09[3:0]) && (v <= max_v);
  endfunction

endpackage

// File: rtl/bcd_pair_dec.sv
// Two-digit packed-BCD decrementer with borrow chaining.
// Ports:
//   value_i    current packed-BCD pair
//   wrap_max_i value produced when decrementing from 00 (borrow_o then set)
//   borrow_i   1: decrement this pair, 0: pass value through
//   value_o    decremented (or passed-through) pair
//   borrow_o   pair underflowed from 00 and needs a borrow from the next pair
module bcd_pair_dec
  import bcd_countdown_timer_pkg::*;
(
  input  logic [7:0] value_i,
  input  logic [7:0] wrap_max_i,
  input  logic       borrow_i,
  output logic [7:0] value_o,
  output logic       borrow_o
);

  always_comb begin
    value_o  = value_i;
    borrow_o = 1'b0;
    if (borrow_i) begin
      if (value_i == 8'h00) begin
        value_o  = wrap_max_i;
        borrow_o = 1'b1;
      end else if (value_i[3:0] == 4'h0) begin
        // units 0 -> 9, tens take the borrow
        value_o = {value_i[7:4] - 4'h1, BCD_09[3:0]};
      end else begin
        value_o = {value_i[7:4], value_i[3:0] - 4'h1};
      end
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Packed-BCD hh:mm:ss countdown timer with load validation, pause/resume,
// expiry flag and optional auto-reload of the last accepted duration.
// Ports:
//   clk, reset_n                clock, async active-low reset
//   ena                         one-cycle count tick
//   load, load_hh/mm/ss         load pulse and BCD duration
//   start, pause                control pulses
//   hh, mm, ss                  remaining time (registered packed BCD)
//   running, expired            state levels (RUN / EXPIRED)
//   done, load_err              one-cycle status pulses
//   state_dbg                   raw FSM state for observation
// Interface note: all inputs are single-cycle strobes sampled on the rising
// edge; there is no backpressure, and done/load_err are one-cycle strobes
// that the consumer must catch on the cycle they are high.
module bcd_countdown_timer
  import bcd_countdown_timer_pkg::*;
#(
  parameter logic [7:0] HH_MAX      = 8'h99,
  parameter bit         AUTO_RELOAD = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ena,
  input  logic       load,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       running,
  output logic       expired,
  output logic       done,
  output logic       load_err,
  output logic [1:0] state_dbg
);

  state_e      state_q, state_d;
  logic [7:0]  hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic [23:0] reload_q, reload_d;
  logic        done_q, done_d;
  logic        load_err_q, load_err_d;

  logic [7:0]  ss_dec, mm_dec, hh_dec;
  logic        ss_borrow, mm_borrow, hh_borrow;
  logic        load_ok, dec_zero, time_zero;

  // Borrow chain: seconds always decrement, carry ripples upward. hh does
  // not wrap; a borrow out of hh only happens from 00:00:00.
  bcd_pair_dec u_ss_dec (
    .value_i(ss_q), .wrap_max_i(BCD_59), .borrow_i(1'b1),
    .value_o(ss_dec), .borrow_o(ss_borrow)
  );
  bcd_pair_dec u_mm_dec (
    .value_i(mm_q), .wrap_max_i(BCD_59), .borrow_i(ss_borrow),
    .value_o(mm_dec), .borrow_o(mm_borrow)
  );
  bcd_pair_dec u_hh_dec (
    .value_i(hh_q), .wrap_max_i(8'h00), .borrow_i(mm_borrow),
    .value_o(hh_dec), .borrow_o(hh_borrow)
  );

  assign load_ok   = bcd_valid(load_hh, HH_MAX) && bcd_valid(load_mm, BCD_59) &&
                     bcd_valid(load_ss, BCD_59);
  assign time_zero = hh_borrow;  // full underflow means the count is 00:00:00
  assign dec_zero  = ({hh_dec, mm_dec, ss_dec} == 24'h0);

  always_comb begin
    state_d    = state_q;
    hh_d       = hh_q;
    mm_d       = mm_q;
    ss_d       = ss_q;
    reload_d   = reload_q;
    done_d     = 1'b0;
    load_err_d = 1'b0;
    // Priority: load > start > pause > ena.
    if (load) begin
      if (state_q != ST_RUN && load_ok) begin
        {hh_d, mm_d, ss_d} = {load_hh, load_mm, load_ss};
        reload_d           = {load_hh, load_mm, load_ss};
        state_d            = ST_IDLE;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (start) begin
      if ((state_q == ST_IDLE || state_q == ST_PAUSED) && !time_zero)
        state_d = ST_RUN;
    end else if (pause) begin
      // The ena of this cycle is dropped because pause outranks it.
      if (state_q == ST_RUN) state_d = ST_PAUSED;
    end else if (ena && state_q == ST_RUN && !time_zero) begin
      done_d = dec_zero;
      if (dec_zero && AUTO_RELOAD && reload_q != 24'h0) begin
        {hh_d, mm_d, ss_d} = reload_q;
      end else begin
        {hh_d, mm_d, ss_d} = {hh_dec, mm_dec, ss_dec};
        if (dec_zero) state_d = ST_EXPIRED;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      hh_q       <= 8'h00;
      mm_q       <= 8'h00;
      ss_q       <= 8'h00;
      reload_q   <= 24'h0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hh_q       <= hh_d;
      mm_q       <= mm_d;
      ss_q       <= ss_d;
      reload_q   <= reload_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
    end
  end

  assign hh        = hh_q;
  assign mm        = mm_q;
  assign ss        = ss_q;
  assign running   = (state_q == ST_RUN);
  assign expired   = (state_q == ST_EXPIRED);
  assign done      = done_q;
  assign load_err  = load_err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: two instances (plain, and HH_MAX=23 with
// auto-reload) share one stimulus stream. A seconds-based reference model
// predicts each cycle's outputs into per-instance queues; a monitor pops and
// compares one entry per instance every clock.
module tb_bcd_countdown_timer;

  localparam int W = 28;  // {hh, mm, ss, running, expired, done, load_err}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b0;
  logic       ena = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [7:0] load_hh = 8'h00, load_mm = 8'h00, load_ss = 8'h00;

  logic [7:0] hh0, mm0, ss0, hh1, mm1, ss1;
  logic       running0, expired0, done0, load_err0;
  logic       running1, expired1, done1, load_err1;
  logic [1:0] state0, state1;

  bcd_countdown_timer #(.HH_MAX(8'h99), .AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .ena(ena), .load(load),
    .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
    .start(start), .pause(pause),
    .hh(hh0), .mm(mm0), .ss(ss0), .running(running0), .expired(expired0),
    .done(done0), .load_err(load_err0), .state_dbg(state0)
  );

  bcd_countdown_timer #(.HH_MAX(8'h23), .AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .ena(ena), .load(load),
    .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
    .start(start), .pause(pause),
    .hh(hh1), .mm(mm1), .ss(ss1), .running(running1), .expired(expired1),
    .done(done1), .load_err(load_err1), .state_dbg(state1)
  );

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_RUN, M_PAUSED, M_EXPIRED} mstate_t;
  mstate_t m_state [2];
  int      m_secs  [2];
  int      m_reload[2];
  int      m_hhmax [2];
  bit      m_auto  [2];

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  function automatic logic [7:0] to_bcd2(input int d);
    return 8'((d / 10) * 16 + (d % 10));
  endfunction

  function automatic bit field_ok(input logic [7:0] v, input int maxd, output int d);
    int hi, lo;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    d  = hi * 10 + lo;
    return (hi <= 9) && (lo <= 9) && (d <= maxd);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i]  = M_IDLE;
      m_secs[i]   = 0;
      m_reload[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input logic ld, st, pa, en,
                            input logic [7:0] h, m, s, output logic [W-1:0] e);
    bit dn, er, okh, okm, oks;
    int dh, dm, ds;
    dn = 1'b0;
    er = 1'b0;
    if (ld) begin
      okh = field_ok(h, m_hhmax[i], dh);
      okm = field_ok(m, 59, dm);
      oks = field_ok(s, 59, ds);
      if (okh && okm && oks && m_state[i] != M_RUN) begin
        m_secs[i]   = dh * 3600 + dm * 60 + ds;
        m_reload[i] = m_secs[i];
        m_state[i]  = M_IDLE;
      end else begin
        er = 1'b1;
      end
    end else if (st) begin
      if ((m_state[i] == M_IDLE || m_state[i] == M_PAUSED) && m_secs[i] != 0)
        m_state[i] = M_RUN;
    end else if (pa) begin
      if (m_state[i] == M_RUN) m_state[i] = M_PAUSED;
    end else if (en && m_state[i] == M_RUN && m_secs[i] > 0) begin
      m_secs[i] = m_secs[i] - 1;
      if (m_secs[i] == 0) begin
        dn = 1'b1;
        if (m_auto[i] && m_reload[i] != 0) m_secs[i] = m_reload[i];
        else m_state[i] = M_EXPIRED;
      end
    end
    e = {to_bcd2(m_secs[i] / 3600), to_bcd2((m_secs[i] / 60) % 60),
         to_bcd2(m_secs[i] % 60), m_state[i] == M_RUN, m_state[i] == M_EXPIRED,
         dn, er};
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic ld, st, pa, en, input logic [7:0] h, m, s);
    logic [W-1:0] e;
    @(negedge clk);
    load = ld; start = st; pause = pa; ena = en;
    load_hh = h; load_mm = m; load_ss = s;
    model_step(0, ld, st, pa, en, h, m, s, e);
    exp_q0.push_back(e);
    model_step(1, ld, st, pa, en, h, m, s, e);
    exp_q1.push_back(e);
  endtask

  task automatic do_load(input logic [7:0] h, m, s); drive(1, 0, 0, 0, h, m, s); endtask
  task automatic do_start(); drive(0, 1, 0, 0, 8'h00, 8'h00, 8'h00); endtask
  task automatic do_pause(); drive(0, 0, 1, 0, 8'h00, 8'h00, 8'h00); endtask
  task automatic do_ena();   drive(0, 0, 0, 1, 8'h00, 8'h00, 8'h00); endtask
  task automatic do_idle();  drive(0, 0, 0, 0, 8'h00, 8'h00, 8'h00); endtask

  task automatic rand_load(output logic [7:0] h, m, s);
    int k;
    k = $urandom_range(0, 9);
    h = 8'h00;
    m = 8'h00;
    s = to_bcd2($urandom_range(1, 9));
    if (k == 4 || k == 5) begin
      h = to_bcd2($urandom_range(0, 30));
      m = to_bcd2($urandom_range(0, 2));
      s = 8'h00;
    end else if (k >= 6) begin
      h = to_bcd2($urandom_range(0, 99));
      m = to_bcd2($urandom_range(0, 59));
      s = to_bcd2($urandom_range(0, 59));
      if (k == 8) m = {4'($urandom_range(0, 5)), 4'($urandom_range(10, 15))};
      if (k == 9) s = {4'($urandom_range(6, 9)), 4'($urandom_range(0, 9))};
    end
  endtask

  // ---------------- scoreboard compare ----------------
  task automatic check_out(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s t=%0t: got %h:%h:%h run=%b exp=%b done=%b err=%b, required %h:%h:%h run=%b exp=%b done=%b err=%b",
               name, $time, got[27:20], got[19:12], got[11:4], got[3], got[2], got[1], got[0],
               exp[27:20], exp[19:12], exp[11:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q0.size() != 0)
      check_out("dut0_cycle", {hh0, mm0, ss0, running0, expired0, done0, load_err0},
                exp_q0.pop_front());
    if (exp_q1.size() != 0)
      check_out("dut1_cycle", {hh1, mm1, ss1, running1, expired1, done1, load_err1},
                exp_q1.pop_front());
  end

  // Asynchronous reset a few ns after an edge; outputs must clear at once.
  task automatic async_reset_check(input string name);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    ena = 1'b1;
    #1;
    check_out({name, "_dut0"}, {hh0, mm0, ss0, running0, expired0, done0, load_err0}, '0);
    check_out({name, "_dut1"}, {hh1, mm1, ss1, running1, expired1, done1, load_err1}, '0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    ena = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] rh, rm, rs;
    int op;
    m_hhmax[0] = 99; m_auto[0] = 1'b0;
    m_hhmax[1] = 23; m_auto[1] = 1'b1;
    model_reset();

    async_reset_check("reset_init");

    // Short countdown to expiry (dut1 reloads instead).
    do_load(8'h00, 8'h00, 8'h03);
    do_start();
    repeat (3) do_ena();
    repeat (2) do_idle();
    do_start();
    do_pause();

    // Borrow across hours.
    do_load(8'h01, 8'h00, 8'h00);
    do_start();
    repeat (2) do_ena();
    do_pause();

    // Invalid loads, and an hours value only dut0 accepts.
    do_load(8'h00, 8'h0A, 8'h00);
    do_load(8'h00, 8'h60, 8'h00);
    do_load(8'h00, 8'h00, 8'h5A);
    do_load(8'hA0, 8'h00, 8'h00);
    do_load(8'h24, 8'h00, 8'h00);
    do_load(8'h99, 8'h59, 8'h59);

    // pause together with ena drops the tick.
    do_load(8'h00, 8'h00, 8'h10);
    do_start();
    drive(0, 0, 1, 1, 8'h00, 8'h00, 8'h00);
    repeat (5) do_ena();
    do_start();
    do_ena();
    do_load(8'h00, 8'h00, 8'h05);  // rejected while running
    do_pause();

    // Auto-reload behaviour.
    do_load(8'h00, 8'h00, 8'h02);
    do_start();
    repeat (4) do_ena();
    do_pause();

    // Reset in the middle of a count.
    do_load(8'h00, 8'h12, 8'h34);
    do_start();
    repeat (3) do_ena();
    async_reset_check("reset_midcount");
    do_start();
    do_ena();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      op = $urandom_range(0, 99);
      if (op < 6) begin
        rand_load(rh, rm, rs);
        do_load(rh, rm, rs);
      end else if (op < 14) do_start();
      else if (op < 18) do_pause();
      else if (op < 21) drive(0, 0, 1, 1, 8'h00, 8'h00, 8'h00);
      else if (op < 85) do_ena();
      else do_idle();
    end

    do_idle();
    @(posedge clk);
    #3;
    n_checks++;
    if (exp_q0.size() == 0 && exp_q1.size() == 0) n_pass++;
    else $display("FAIL queue_drain: got %0d/%0d entries left, required 0/0",
                  exp_q0.size(), exp_q1.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
